// File: rtl/mig_app_responder.sv
// BRAM-backed stand-in for the MIG 7-series app_* user interface (in-order, fixed read latency).
// Define MIG_RESP_STALL_EN to add LFSR-driven backpressure on app_rdy / app_wdf_rdy.
module mig_app_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int ADDR_LSB     = 3,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64
) (
  input  logic         ui_clk,
  input  logic         sys_rst_n,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [255:0] app_wdf_data,
  input  logic [31:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [255:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         err_sticky
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int WAW = $clog2(WDF_DEPTH);
  localparam int CCW = $clog2(CALIB_CYCLES + 1);
  localparam int CEW = 3 + DEPTH_LOG2;
  localparam int WEW = 32 + 256;

  logic [CCW-1:0]  r_calib_cnt;
  logic            r_calib;
  logic [CEW-1:0]  r_cmd_mem [CMD_DEPTH];
  logic [CAW:0]    r_cmd_wr;
  logic [CAW:0]    r_cmd_rd;
  logic [WEW-1:0]  r_wdf_mem [WDF_DEPTH];
  logic [WAW:0]    r_wdf_wr;
  logic [WAW:0]    r_wdf_rd;
  logic [255:0]    r_mem [2**DEPTH_LOG2];
  logic            r_rd_vld_p [RD_LATENCY];
  logic [255:0]    r_rd_dat_p [RD_LATENCY];
  logic            r_err;

  logic                  w_cmd_full, w_cmd_empty, w_wdf_full, w_wdf_empty;
  logic                  w_cmd_push, w_wdf_push;
  logic                  w_cmd_stall, w_wdf_stall;
  logic [2:0]            w_head_cmd;
  logic [DEPTH_LOG2-1:0] w_head_idx;
  logic [31:0]           w_head_mask;
  logic [255:0]          w_head_data;
  logic                  w_exec_wr, w_exec_rd, w_exec_ill;
  logic                  w_unused_addr;

  // Upper address bits only alias; they are intentionally dropped.
  assign w_unused_addr = ^app_addr;

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_calib_cnt <= '0;
      r_calib     <= 1'b0;
    end else if (!r_calib) begin
      r_calib_cnt <= r_calib_cnt + 1'b1;
      if (r_calib_cnt == CCW'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
    end
  end

`ifdef MIG_RESP_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_lfsr <= 16'hACE1;
    else            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_cmd_stall = (r_lfsr[1:0] == 2'b00);
  assign w_wdf_stall = (r_lfsr[3:2] == 2'b00);
`else
  assign w_cmd_stall = 1'b0;
  assign w_wdf_stall = 1'b0;
`endif

  assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
  assign w_cmd_full  = ((r_cmd_wr - r_cmd_rd) == (CAW+1)'(CMD_DEPTH));
  assign w_wdf_empty = (r_wdf_wr == r_wdf_rd);
  assign w_wdf_full  = ((r_wdf_wr - r_wdf_rd) == (WAW+1)'(WDF_DEPTH));

  assign app_rdy     = r_calib && !w_cmd_full && !w_cmd_stall;
  assign app_wdf_rdy = r_calib && !w_wdf_full && !w_wdf_stall;
  assign w_cmd_push  = app_en && app_rdy;
  assign w_wdf_push  = app_wdf_wren && app_wdf_rdy;

  assign {w_head_cmd, w_head_idx}   = r_cmd_mem[r_cmd_rd[CAW-1:0]];
  assign {w_head_mask, w_head_data} = r_wdf_mem[r_wdf_rd[WAW-1:0]];

  // A write at the head waits for its paired data beat; everything behind it waits too.
  assign w_exec_wr  = !w_cmd_empty && (w_head_cmd == 3'b000) && !w_wdf_empty;
  assign w_exec_rd  = !w_cmd_empty && (w_head_cmd == 3'b001);
  assign w_exec_ill = !w_cmd_empty && (w_head_cmd[2:1] != 2'b00);

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd_wr <= '0;
      r_cmd_rd <= '0;
      r_wdf_wr <= '0;
      r_wdf_rd <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_cmd_push)                           r_cmd_wr <= r_cmd_wr + 1'b1;
      if (w_exec_wr || w_exec_rd || w_exec_ill) r_cmd_rd <= r_cmd_rd + 1'b1;
      if (w_wdf_push)                           r_wdf_wr <= r_wdf_wr + 1'b1;
      if (w_exec_wr)                            r_wdf_rd <= r_wdf_rd + 1'b1;
      if (w_exec_ill || (app_wdf_wren && !app_wdf_end)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wr[CAW-1:0]] <= {app_cmd, app_addr[ADDR_LSB +: DEPTH_LOG2]};
    if (w_wdf_push) r_wdf_mem[r_wdf_wr[WAW-1:0]] <= {app_wdf_mask, app_wdf_data};
  end

  always_ff @(posedge ui_clk) begin
    if (w_exec_wr) begin
      for (int b = 0; b < 32; b++) begin
        if (!w_head_mask[b]) r_mem[w_head_idx][8*b +: 8] <= w_head_data[8*b +: 8];
      end
    end
  end

  // Stage p0: BRAM read; stages p1..pN-1: fixed-latency delay line, never stalls.
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_rd_vld_p[i] <= 1'b0;
    end else begin
      r_rd_vld_p[0] <= w_exec_rd;
      for (int i = 1; i < RD_LATENCY; i++) r_rd_vld_p[i] <= r_rd_vld_p[i-1];
    end
  end

  always_ff @(posedge ui_clk) begin
    r_rd_dat_p[0] <= r_mem[w_head_idx];
    for (int i = 1; i < RD_LATENCY; i++) r_rd_dat_p[i] <= r_rd_dat_p[i-1];
  end

  assign app_rd_data_valid   = r_rd_vld_p[RD_LATENCY-1];
  assign app_rd_data_end     = r_rd_vld_p[RD_LATENCY-1];
  assign app_rd_data         = r_rd_vld_p[RD_LATENCY-1] ? r_rd_dat_p[RD_LATENCY-1] : '0;
  assign init_calib_complete = r_calib;
  assign err_sticky          = r_err;

endmodule
